mem_block_mover: RTL and testbench
==================================

Name: mem_block_mover

Overview:
- Bus-initiator engine that drives the single-port 64-word data memory port (A, WE, WD, RD) to copy or fill a block of words without processor involvement.
- Sits between the control logic and the data memory.
- Shares the memory port through an external mux, selected by BUSY.
- Issues one memory access per cycle and reports completion plus a running checksum of the words written.

Parameters:
- AW, 6, memory address width (64 words).
- DW, 32, data word width.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- MODE  input  1  0 = copy SRC->DST, 1 = fill DST with FILL_VAL.
- SRC  input  AW  first source word address (copy only).
- DST  input  AW  first destination word address.
- LEN  input  AW+1  word count, 0..64; values >64 clipped to 64.
- FILL_VAL  input  DW  fill pattern (fill only).
- MEM_A  output  AW  address to data memory.
- MEM_WE  output  1  write enable to data memory.
- MEM_WD  output  DW  write data to data memory.
- MEM_RD  input  DW  combinational read data from data memory (valid same cycle as MEM_A).
- BUSY  output  1  high in READ/WRITE states.
- DONE  output  1  one-cycle completion pulse.
- SUM  output  DW  mod-2^DW sum of all words written by the last operation.

Behaviour:
- Reset (RESET_N low, async): state IDLE; MEM_A=0, MEM_WE=0, MEM_WD=0, BUSY=0, DONE=0, SUM=0; internal pointers, counter and data register = 0.
- Reset asserted mid-operation aborts immediately. No further writes occur; memory contents already written stay written.
- States are IDLE, READ, WRITE, DONE. All outputs are registered or decoded from registered state only; there is no combinational path from START to the memory outputs.
- IDLE: MEM_WE=0, MEM_A=0.
  - On START=1 at an edge: latch SRC, DST, MODE, clipped LEN into src_ptr, dst_ptr, mode_r, remaining; clear SUM to 0.
  - Next state: LEN==0 -> DONE; MODE=0 -> READ; MODE=1 -> WRITE.
- READ: MEM_A=src_ptr, MEM_WE=0. At the edge, data_r <= MEM_RD, src_ptr <= src_ptr+1 (mod 64); next state WRITE.
- WRITE: MEM_A=dst_ptr, MEM_WE=1, MEM_WD = data_r (copy) or FILL_VAL latched at start (fill).
  - At the edge: SUM += MEM_WD, dst_ptr <= dst_ptr+1 (mod 64), remaining -= 1.
  - If remaining was 1 -> DONE; else copy -> READ, fill -> WRITE.
- DONE: DONE=1 for exactly one cycle, BUSY=0, MEM_WE=0; next state IDLE. SUM holds until the next accepted START.
- Latency, with START sampled at edge 0:
  - Copy of L words: DONE high in cycle 2L+1.
  - Fill: DONE high in cycle L+1.
  - LEN=0: DONE high in cycle 1 with no memory access.
- START while BUSY or in DONE is ignored; it is not queued.
- Address wrap-around: pointers wrap 63->0 silently; a 64-word operation touches every location exactly once.
- Overlap: copy proceeds strictly forward, one word read then one word written.
  - With DST in (SRC, SRC+LEN) mod 64, later reads observe earlier writes; this produces pattern replication and is the defined behaviour.
  - SRC==DST rewrites the data unchanged.
- The engine never asserts MEM_WE outside WRITE.

Test Plan:
- Copy: memory[0..3]=0x11,0x22,0x33,0x44; START MODE=0 SRC=0 DST=8 LEN=4 -> memory[8..11]=0x11..0x44; DONE pulse in cycle 9; SUM=0xAA; BUSY high cycles 1-8.
- Fill with wrap: START MODE=1 DST=62 LEN=4 FILL_VAL=0xDEADBEEF -> words 62,63,0,1 written; word 2 unchanged; DONE in cycle 5; SUM=0x7AB6FBBC.
- Zero length and ignored start: LEN=0 -> DONE in cycle 1, MEM_WE never high. START pulsed during an active copy -> ignored; the original operation completes exactly as specified.
- Overlapping copy: memory[0]=0xA, memory[1]=0xB; SRC=0 DST=1 LEN=3 -> memory[1..3]=0xA,0xA,0xA.
- Reset mid-operation: drop RESET_N during WRITE of word 2 of a 4-word fill -> outputs immediately reset values; only words 0-1 written; next START runs normally.
- LEN clip: LEN=100 fill -> exactly 64 writes, all 64 locations equal FILL_VAL, DONE in cycle 65.

Source files
------------

// File: rtl/mem_block_mover.sv
// Block copy/fill engine that owns the single-port data memory while BUSY.
// Performs one memory access per cycle and keeps a running sum of written words.
module mem_block_mover #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          START,
    input  logic          MODE,
    input  logic [AW-1:0] SRC,
    input  logic [AW-1:0] DST,
    input  logic [AW:0]   LEN,
    input  logic [DW-1:0] FILL_VAL,
    output logic [AW-1:0] MEM_A,
    output logic          MEM_WE,
    output logic [DW-1:0] MEM_WD,
    input  logic [DW-1:0] MEM_RD,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] SUM
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_LEFT = {{AW{1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic          mode_r;
    logic [AW:0]   remaining;
    logic [DW-1:0] data_r;
    logic [DW-1:0] fill_r;
    logic [AW:0]   len_clip;

    assign len_clip = (LEN > MAX_LEN) ? MAX_LEN : LEN;

    // Write data is a pure decode of registers, so it is already valid in the WRITE cycle.
    assign MEM_WD = mode_r ? fill_r : data_r;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            mode_r    <= 1'b0;
            remaining <= '0;
            data_r    <= '0;
            fill_r    <= '0;
            MEM_A     <= '0;
            MEM_WE    <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            SUM       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    MEM_A  <= '0;
                    MEM_WE <= 1'b0;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b0;
                    if (START) begin
                        src_ptr   <= SRC;
                        dst_ptr   <= DST;
                        mode_r    <= MODE;
                        remaining <= len_clip;
                        fill_r    <= FILL_VAL;
                        SUM       <= '0;
                        if (len_clip == '0) begin
                            state <= S_DONE;
                            DONE  <= 1'b1;
                        end else if (!MODE) begin
                            state <= S_READ;
                            MEM_A <= SRC;
                            BUSY  <= 1'b1;
                        end else begin
                            state  <= S_WRITE;
                            MEM_A  <= DST;
                            MEM_WE <= 1'b1;
                            BUSY   <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    data_r  <= MEM_RD;
                    src_ptr <= src_ptr + 1'b1;
                    state   <= S_WRITE;
                    MEM_A   <= dst_ptr;
                    MEM_WE  <= 1'b1;
                end
                S_WRITE: begin
                    SUM       <= SUM + MEM_WD;
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == ONE_LEFT) begin
                        state  <= S_DONE;
                        MEM_A  <= '0;
                        MEM_WE <= 1'b0;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                    end else if (!mode_r) begin
                        state  <= S_READ;
                        MEM_A  <= src_ptr;
                        MEM_WE <= 1'b0;
                    end else begin
                        MEM_A <= dst_ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    MEM_A  <= '0;
                    MEM_WE <= 1'b0;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    MEM_WE <= 1'b0;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover: behavioural memory, write scoreboard,
// latency/BUSY/SUM checks per operation and a full memory image comparison.
module tb_mem_block_mover;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic          MODE = 1'b0;
    logic [AW-1:0] SRC = '0;
    logic [AW-1:0] DST = '0;
    logic [AW:0]   LEN = '0;
    logic [DW-1:0] FILL_VAL = '0;
    logic [AW-1:0] MEM_A;
    logic          MEM_WE;
    logic [DW-1:0] MEM_WD;
    logic [DW-1:0] MEM_RD;
    logic          BUSY;
    logic          DONE;
    logic [DW-1:0] SUM;

    logic [DW-1:0] mem   [64];
    logic [DW-1:0] model [64];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [DW-1:0] poke_d = '0;

    logic [AW+DW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    mem_block_mover #(.AW(AW), .DW(DW)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .MODE     (MODE),
        .SRC      (SRC),
        .DST      (DST),
        .LEN      (LEN),
        .FILL_VAL (FILL_VAL),
        .MEM_A    (MEM_A),
        .MEM_WE   (MEM_WE),
        .MEM_WD   (MEM_WD),
        .MEM_RD   (MEM_RD),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .SUM      (SUM)
    );

    // Behavioural data memory: combinational read, write on rising edge.
    assign MEM_RD = mem[MEM_A];

    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_A] <= MEM_WD;
        else if (poke_en) mem[poke_a] <= poke_d;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write cycle seen by the memory must match the next expected write.
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL wr_unexpected observed a=%0d d=%0h expected no write", MEM_A, MEM_WD);
            end
            if (exp_q.size() != 0) chk("wr_addr_data", {MEM_A, MEM_WD}, exp_q.pop_front());
            chk("we_with_busy", BUSY, 1);
        end
    end

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== model[i]) n++;
        return n;
    endfunction

    task automatic poke(input int a, input logic [DW-1:0] d);
        @(negedge CLK);
        poke_en = 1'b1;
        poke_a  = AW'(a);
        poke_d  = d;
        model[a] = d;
        @(posedge CLK);
        #1 poke_en = 1'b0;
    endtask

    task automatic run_op(input logic m, input int src, input int dst, input int len,
                          input logic [DW-1:0] fv, input int pulse_at);
        int eff, k, busy_n, exp_k;
        logic [AW-1:0] a, sa;
        logic [DW-1:0] d, s;
        eff = (len > 64) ? 64 : len;
        s = '0;
        for (int i = 0; i < eff; i++) begin
            a  = AW'(dst + i);
            sa = AW'(src + i);
            d  = m ? fv : model[sa];
            model[a] = d;
            exp_q.push_back({a, d});
            s = s + d;
        end
        exp_k = (eff == 0) ? 0 : (m ? eff : 2 * eff);
        @(negedge CLK);
        START = 1'b1; MODE = m; SRC = AW'(src); DST = AW'(dst);
        LEN = (AW+1)'(len); FILL_VAL = fv;
        @(posedge CLK);
        #1 START = 1'b0;
        k = 0;
        busy_n = 0;
        @(negedge CLK);
        while (!DONE && k < 300) begin
            if (BUSY) busy_n++;
            if (k == pulse_at) begin
                START = 1'b1; MODE = ~m; DST = AW'(dst + 5); LEN = (AW+1)'(5);
            end
            @(posedge CLK);
            #1 START = 1'b0;
            @(negedge CLK);
            k++;
        end
        chk("done_latency", k, exp_k);
        chk("busy_cycles", busy_n, exp_k);
        chk("sum", SUM, s);
        chk("busy_at_done", BUSY, 0);
        chk("we_at_done", MEM_WE, 0);
        @(negedge CLK);
        chk("done_one_cycle", DONE, 0);
        chk("sum_hold", SUM, s);
        chk("mem_image", mem_diff(), 0);
    endtask

    initial begin
        int rs, rd, rl;
        #3;
        chk("rst_mem_a", MEM_A, 0);
        chk("rst_mem_we", MEM_WE, 0);
        chk("rst_mem_wd", MEM_WD, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_sum", SUM, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);

        run_op(1'b0, 0, 8, 4, '0, -1);
        chk("copy_sum_const", SUM, 32'hAA);
        chk("copy_w8", mem[8], 32'h11);
        chk("copy_w11", mem[11], 32'h44);

        run_op(1'b1, 0, 62, 4, 32'hDEADBEEF, -1);
        chk("fill_sum_const", SUM, 32'h7AB6FBBC);
        chk("fill_w63", mem[63], 32'hDEADBEEF);
        chk("fill_w1", mem[1], 32'hDEADBEEF);
        chk("fill_w2_untouched", mem[2], 32'h33);

        run_op(1'b1, 0, 30, 0, 32'h12345678, -1);
        chk("len0_sum", SUM, 0);

        rl = $urandom_range(3, 8);
        run_op(1'b0, 16, 24, rl, '0, 3);

        poke(0, 32'hA); poke(1, 32'hB);
        run_op(1'b0, 0, 1, 3, '0, -1);
        chk("overlap_w1", mem[1], 32'hA);
        chk("overlap_w2", mem[2], 32'hA);
        chk("overlap_w3", mem[3], 32'hA);

        run_op(1'b0, 40, 40, 5, '0, -1);
        rs = $urandom_range(0, 63);
        rd = $urandom_range(0, 63);
        rl = $urandom_range(1, 20);
        run_op(1'b0, rs, rd, rl, '0, -1);

        // Abort a 4-word fill while word 2 is on the bus; only words 0-1 land.
        model[20] = 32'h5555AAAA; model[21] = 32'h5555AAAA;
        exp_q.push_back({6'd20, 32'h5555AAAA});
        exp_q.push_back({6'd21, 32'h5555AAAA});
        @(negedge CLK);
        START = 1'b1; MODE = 1'b1; DST = 6'd20; LEN = 7'd4; FILL_VAL = 32'h5555AAAA;
        @(posedge CLK);
        #1 START = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("abort_pre_a", MEM_A, 22);
        chk("abort_pre_we", MEM_WE, 1);
        RESET_N = 1'b0;
        #1;
        chk("abort_mem_a", MEM_A, 0);
        chk("abort_mem_we", MEM_WE, 0);
        chk("abort_mem_wd", MEM_WD, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_sum", SUM, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        chk("abort_mem_image", mem_diff(), 0);
        chk("abort_q_drained", exp_q.size(), 0);

        run_op(1'b1, 0, 50, 2, 32'h0BADF00D, -1);
        run_op(1'b1, 0, 7, 100, 32'h5A5A1234, -1);
        chk("clip_sum_const", SUM, 32'h96848D00);
        chk("clip_w6", mem[6], 32'h5A5A1234);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
